// File: rtl/regfile_pkg.sv
// Shared sizing constants and types for the 32 x 64-bit general-purpose register file.
package regfile_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] reg_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    localparam addr_t ZERO_REG = addr_t'(31);

endpackage

// File: rtl/register_file_if.sv
// Register file bus: two read ports and one write port, driven by the datapath (master).
interface register_file_if;
    import regfile_pkg::*;

    reg_t  BusA;
    reg_t  BusB;
    reg_t  BusW;
    addr_t RA;
    addr_t RB;
    addr_t RW;
    logic  RegWr;

    modport master (
        output RA, RB, RW, BusW, RegWr,
        input  BusA, BusB
    );

    modport slave (
        input  RA, RB, RW, BusW, RegWr,
        output BusA, BusB
    );

endinterface

// File: rtl/regfile_read_port.sv
// Combinational 32:1 read mux; the zero register always reads 0 regardless of storage.
module regfile_read_port
    import regfile_pkg::*;
(
    input  reg_t  regs [NUM_REGS],
    input  addr_t addr,
    output reg_t  data
);

    // NOTE: both arms of the ternary assign data, so no latch can be inferred.
    always_comb begin
        data = (addr == ZERO_REG) ? '0 : regs[addr];
    end

endmodule

// File: rtl/register_file.sv
// 32 x 64-bit register file: falling-edge write, async clear, two combinational read ports.
module register_file
    import regfile_pkg::*;
(
    input  logic            Clk,
    input  logic            Rst_n,
    register_file_if.slave  bus
);

    reg_t regs [NUM_REGS];

    // NOTE: this array is cleared on reset on purpose; an all-zero register file is part of the
    // architectural reset state, so the usual "don't reset memories" rule does not apply here.
    always_ff @(negedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.RegWr && (bus.RW != ZERO_REG)) begin
            regs[bus.RW] <= bus.BusW;
        end
    end

    // The zero-register entry is never written, so it holds its reset value of 0
    // and synthesis reduces it to a constant.
    regfile_read_port u_read_a (
        .regs (regs),
        .addr (bus.RA),
        .data (bus.BusA)
    );

    regfile_read_port u_read_b (
        .regs (regs),
        .addr (bus.RB),
        .data (bus.BusB)
    );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized traffic vs. an array model.
module tb_register_file;
    import regfile_pkg::*;

    logic Clk;
    logic Rst_n;

    register_file_if bus ();

    register_file dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: index 31 is never stored, it is simply read as 0.
    logic [63:0] model [32];
    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [63:0] expect_rd(input int idx);
        return (idx == 31) ? 64'd0 : model[idx];
    endfunction

    // n written "as hex digits": 10 -> 0x10, 25 -> 0x25
    function automatic logic [63:0] hex_digits(input int n);
        return 64'((n / 10) * 16 + (n % 10));
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 64'd0;
    endtask

    // Drive one write in the high phase, let the falling edge commit it, update the model.
    task automatic do_write(input int idx, input logic [63:0] data, input logic en);
        @(posedge Clk); #1;
        bus.RW    = addr_t'(idx);
        bus.BusW  = data;
        bus.RegWr = en;
        @(negedge Clk); #1;
        if (en && idx != 31) model[idx] = data;
        bus.RegWr = 1'b0;
    endtask

    task automatic test_reset();
        Rst_n = 1'b1;
        #2 Rst_n = 1'b0;
        #4 Rst_n = 1'b1;
        clear_model();
        for (int i = 0; i < 32; i++) begin
            bus.RA = addr_t'(i);
            bus.RB = addr_t'(i);
            #1;
            vectors++;
            if (bus.BusA !== 64'd0 || bus.BusB !== 64'd0) begin
                miscompares++;
                $display("FAIL reset idx=%0d got A=%h B=%h exp 0", i, bus.BusA, bus.BusB);
            end
        end
    endtask

    task automatic test_zero_reg();
        bus.RA = addr_t'(31);
        bus.RB = addr_t'(31);
        #1;
        vectors++;
        if (bus.BusA !== 64'd0 || bus.BusB !== 64'd0) begin
            miscompares++;
            $display("FAIL zero_before got A=%h B=%h exp 0", bus.BusA, bus.BusB);
        end
        do_write(31, 64'h12345678, 1'b1);
        vectors++;
        if (bus.BusA !== 64'd0 || bus.BusB !== 64'd0) begin
            miscompares++;
            $display("FAIL zero_after got A=%h B=%h exp 0", bus.BusA, bus.BusB);
        end
    endtask

    task automatic test_fill();
        for (int n = 0; n < 31; n++) do_write(n, hex_digits(n), 1'b1);
        bus.RA = addr_t'(0);
        bus.RB = addr_t'(0);
        #1;
        vectors++;
        if (bus.BusA !== 64'd0) begin
            miscompares++;
            $display("FAIL fill idx=0 got=%h exp=0", bus.BusA);
        end
        for (int n = 1; n < 31; n += 2) begin
            bus.RA = addr_t'(n);
            bus.RB = addr_t'(n + 1);
            #1;
            vectors++;
            if (bus.BusA !== hex_digits(n) || bus.BusB !== hex_digits(n + 1)) begin
                miscompares++;
                $display("FAIL fill pair=(%0d,%0d) got A=%h B=%h exp A=%h B=%h",
                         n, n + 1, bus.BusA, bus.BusB, hex_digits(n), hex_digits(n + 1));
            end
        end
    endtask

    task automatic test_read_during_write();
        @(posedge Clk); #1;
        bus.RA    = addr_t'(1);
        bus.RB    = addr_t'(2);
        bus.RW    = addr_t'(1);
        bus.BusW  = 64'h12345678;
        bus.RegWr = 1'b1;
        #1;
        vectors++;
        if (bus.BusA !== 64'h1 || bus.BusB !== 64'h2) begin
            miscompares++;
            $display("FAIL rdw_before got A=%h B=%h exp A=1 B=2", bus.BusA, bus.BusB);
        end
        @(negedge Clk); #1;
        model[1] = 64'h12345678;
        bus.RegWr = 1'b0;
        vectors++;
        if (bus.BusA !== 64'h12345678 || bus.BusB !== 64'h2) begin
            miscompares++;
            $display("FAIL rdw_after got A=%h B=%h exp A=12345678 B=2", bus.BusA, bus.BusB);
        end
    endtask

    task automatic test_write_disable();
        do_write(3, 64'h12345678, 1'b0);
        for (int i = 0; i < 32; i++) begin
            bus.RA = addr_t'(i);
            bus.RB = addr_t'(31 - i);
            #1;
            vectors++;
            if (bus.BusA !== expect_rd(i) || bus.BusB !== expect_rd(31 - i)) begin
                miscompares++;
                $display("FAIL wr_disable idx=%0d got A=%h B=%h exp A=%h B=%h",
                         i, bus.BusA, bus.BusB, expect_rd(i), expect_rd(31 - i));
            end
        end
    endtask

    task automatic test_async_reset();
        @(posedge Clk); #1;
        bus.RA = addr_t'(10);
        bus.RB = addr_t'(20);
        #1;
        Rst_n = 1'b0;
        #1;
        clear_model();
        vectors++;
        if (bus.BusA !== 64'd0 || bus.BusB !== 64'd0) begin
            miscompares++;
            $display("FAIL async_reset got A=%h B=%h exp 0", bus.BusA, bus.BusB);
        end
        // Write attempted while reset is held: reset must win.
        bus.RW    = addr_t'(5);
        bus.BusW  = 64'hDEAD_BEEF_CAFE_F00D;
        bus.RegWr = 1'b1;
        @(negedge Clk); #1;
        bus.RegWr = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.RA = addr_t'(i);
            bus.RB = addr_t'(i);
            #1;
            vectors++;
            if (bus.BusA !== 64'd0 || bus.BusB !== 64'd0) begin
                miscompares++;
                $display("FAIL reset_hold idx=%0d got A=%h B=%h exp 0", i, bus.BusA, bus.BusB);
            end
        end
        @(posedge Clk); #1;
        Rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [63:0] pre_a, pre_b;
        int ra, rb, rw;
        logic en;
        logic [63:0] data;
        for (int k = 0; k < 300; k++) begin
            rw   = $urandom_range(31, 0);
            ra   = ($urandom_range(3, 0) == 0) ? rw : $urandom_range(31, 0);
            rb   = ($urandom_range(3, 0) == 0) ? ra : $urandom_range(31, 0);
            en   = ($urandom_range(3, 0) != 0);
            data = {$urandom, $urandom};
            @(posedge Clk); #1;
            bus.RA    = addr_t'(ra);
            bus.RB    = addr_t'(rb);
            bus.RW    = addr_t'(rw);
            bus.BusW  = data;
            bus.RegWr = en;
            #1;
            pre_a = expect_rd(ra);
            pre_b = expect_rd(rb);
            vectors++;
            if (bus.BusA !== pre_a || bus.BusB !== pre_b) begin
                miscompares++;
                $display("FAIL rand_pre k=%0d ra=%0d rb=%0d got A=%h B=%h exp A=%h B=%h",
                         k, ra, rb, bus.BusA, bus.BusB, pre_a, pre_b);
            end
            @(negedge Clk); #1;
            if (en && rw != 31) model[rw] = data;
            vectors++;
            if (bus.BusA !== expect_rd(ra) || bus.BusB !== expect_rd(rb)) begin
                miscompares++;
                $display("FAIL rand_post k=%0d ra=%0d rb=%0d rw=%0d en=%0b got A=%h B=%h exp A=%h B=%h",
                         k, ra, rb, rw, en, bus.BusA, bus.BusB, expect_rd(ra), expect_rd(rb));
            end
            bus.RegWr = 1'b0;
        end
        for (int i = 0; i < 32; i++) begin
            bus.RA = addr_t'(i);
            bus.RB = addr_t'(i);
            #1;
            vectors++;
            if (bus.BusA !== expect_rd(i) || bus.BusB !== expect_rd(i)) begin
                miscompares++;
                $display("FAIL rand_final idx=%0d got A=%h B=%h exp=%h",
                         i, bus.BusA, bus.BusB, expect_rd(i));
            end
        end
    endtask

    initial begin
        bus.RA    = '0;
        bus.RB    = '0;
        bus.RW    = '0;
        bus.BusW  = '0;
        bus.RegWr = 1'b0;
        clear_model();
        test_reset();
        test_zero_reg();
        test_fill();
        test_read_during_write();
        test_write_disable();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
